// File: rtl/instr_prefetch_aligner_if.sv
// Instruction bus between the prefetch buffer (master) and instruction memory (slave).
interface instr_prefetch_aligner_if;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_gnt_i,
        input  instr_rvalid_i,
        input  instr_rdata_i,
        input  instr_err_i
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_gnt_i,
        output instr_rvalid_i,
        output instr_rdata_i,
        output instr_err_i
    );
endinterface

// File: rtl/instr_prefetch_aligner.sv
// IF-stage prefetch buffer with RVC aligner: keeps up to NUM_REQS bus
// transactions in flight, buffers responses in a shift FIFO and extracts
// 16/32-bit instructions at any halfword PC. Redirects flush the FIFO and
// discard responses still in flight for the old stream.
module instr_prefetch_aligner #(
    parameter logic [31:0] PC_RESET   = 32'h0,
    parameter int unsigned FIFO_DEPTH = 3,
    parameter int unsigned NUM_REQS   = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    instr_prefetch_aligner_if.master        bus,
    input  logic                            wb_change_pc_i,
    input  logic [31:0]                     wb_next_pc_i,
    input  logic                            alu_change_pc_i,
    input  logic [31:0]                     alu_next_pc_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [31:0]                     out_instr_o,
    output logic [31:0]                     out_pc_o,
    output logic                            out_compressed_o,
    output logic                            out_err_o
);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW:0] NREQ_L  = (CW + 1)'(NUM_REQS);

    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic          fifo_err  [FIFO_DEPTH];
    logic [CW-1:0] fifo_count, fifo_count_nxt;
    logic [CW-1:0] outstanding, outstanding_nxt;
    logic [CW-1:0] discard, discard_nxt;
    logic [CW-1:0] wr_idx;
    logic [CW:0]   occupancy_nxt;
    logic          kill_pending;
    logic [31:0]   redirect_addr;
    logic [31:0]   pc_q;
    logic [31:0]   pc_new;
    logic [31:0]   w0;
    logic          grant, redirect, push, pop, fire, req_nxt;
    logic          pc_half, compressed, need_two, avail;
    logic          unused_pc_bit;

    // Aligner view of the FIFO head plus next-state bookkeeping
    always_comb begin
        grant      = bus.instr_req_o & bus.instr_gnt_i;
        redirect   = wb_change_pc_i | alu_change_pc_i;
        pc_new     = wb_change_pc_i ? wb_next_pc_i : alu_next_pc_i;
        unused_pc_bit = pc_new[0];

        w0         = fifo_data[0];
        pc_half    = pc_q[1];
        compressed = pc_half ? (w0[17:16] != 2'b11) : (w0[1:0] != 2'b11);
        need_two   = pc_half & ~compressed;
        avail      = need_two ? (fifo_count >= CW'(2)) : (fifo_count != '0);

        out_valid_o      = avail & ~redirect;
        out_pc_o         = pc_q;
        out_compressed_o = compressed;
        out_err_o        = fifo_err[0] | (need_two & fifo_err[1]);
        if (!pc_half)
            out_instr_o = compressed ? {16'h0, w0[15:0]} : w0;
        else
            out_instr_o = compressed ? {16'h0, w0[31:16]} : {fifo_data[1][15:0], w0[31:16]};

        fire = out_valid_o & out_ready_i;
        // A compressed instruction in the low half leaves the word for its upper half
        pop  = fire & (pc_half | ~compressed);
        push = bus.instr_rvalid_i & (discard == '0) & ~redirect;

        outstanding_nxt = outstanding + CW'(grant) - CW'(bus.instr_rvalid_i);
        fifo_count_nxt  = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
        wr_idx          = fifo_count - CW'(pop);

        // Redirect marks everything in flight (incl. this cycle's grant) as stale;
        // a request held across a redirect becomes stale when finally granted
        if (redirect)
            discard_nxt = outstanding_nxt;
        else
            discard_nxt = discard - CW'(bus.instr_rvalid_i & (discard != '0))
                                  + CW'(grant & kill_pending);

        occupancy_nxt = {1'b0, fifo_count_nxt} + {1'b0, outstanding_nxt};
        req_nxt = (bus.instr_req_o & ~bus.instr_gnt_i)
                | ((occupancy_nxt < DEPTH_L) & ({1'b0, outstanding_nxt} < NREQ_L));
    end

    // Bus side: request/address issue, in-flight and discard counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.instr_req_o  <= 1'b0;
            bus.instr_addr_o <= {PC_RESET[31:2], 2'b00};
            outstanding      <= '0;
            discard          <= '0;
            kill_pending     <= 1'b0;
            redirect_addr    <= '0;
        end else begin
            bus.instr_req_o <= req_nxt;
            outstanding     <= outstanding_nxt;
            discard         <= discard_nxt;
            if (redirect) begin
                if (bus.instr_req_o & ~bus.instr_gnt_i) begin
                    kill_pending  <= 1'b1;
                    redirect_addr <= {pc_new[31:2], 2'b00};
                end else begin
                    kill_pending     <= 1'b0;
                    bus.instr_addr_o <= {pc_new[31:2], 2'b00};
                end
            end else if (grant) begin
                kill_pending     <= 1'b0;
                bus.instr_addr_o <= kill_pending ? redirect_addr : bus.instr_addr_o + 32'd4;
            end
        end
    end

    // Response FIFO: head at index 0, shifts down on pop, push lands after the shift
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_err[i]  <= 1'b0;
            end
        end else begin
            fifo_count <= fifo_count_nxt;
            if (!redirect) begin
                if (pop) begin
                    for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
                        fifo_data[i] <= fifo_data[i + 1];
                        fifo_err[i]  <= fifo_err[i + 1];
                    end
                end
                if (push) begin
                    fifo_data[wr_idx] <= bus.instr_rdata_i;
                    fifo_err[wr_idx]  <= bus.instr_err_i;
                end
            end
        end
    end

    // Decode-side PC: redirect target or advance by instruction size on accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            pc_q <= {PC_RESET[31:1], 1'b0};
        else if (redirect)
            pc_q <= {pc_new[31:1], 1'b0};
        else if (fire)
            pc_q <= pc_q + (compressed ? 32'd2 : 32'd4);
    end
endmodule

// File: tb/tb_instr_prefetch_aligner.sv
// Directed bench for instr_prefetch_aligner: a memory responder grants and
// answers in order one cycle later; the main sequence checks hand-computed
// instruction streams across reset, RVC alignment, redirects, stall and errors.
module tb_instr_prefetch_aligner;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wb_change_pc_i = 1'b0;
    logic [31:0] wb_next_pc_i = '0;
    logic        alu_change_pc_i = 1'b0;
    logic [31:0] alu_next_pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_compressed_o;
    logic        out_err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [logic [31:0]];
    logic        mem_err [logic [31:0]];
    logic [31:0] q [$];
    logic        gnt_en  = 1'b1;
    logic        resp_en = 1'b1;
    int          stall_push = 0;
    logic [31:0] resp_addr;

    always #5 clk = ~clk;

    instr_prefetch_aligner_if bus ();

    instr_prefetch_aligner #(
        .PC_RESET  (32'h80),
        .FIFO_DEPTH(3),
        .NUM_REQS  (2)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus.master),
        .wb_change_pc_i  (wb_change_pc_i),
        .wb_next_pc_i    (wb_next_pc_i),
        .alu_change_pc_i (alu_change_pc_i),
        .alu_next_pc_i   (alu_next_pc_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_instr_o     (out_instr_o),
        .out_pc_o        (out_pc_o),
        .out_compressed_o(out_compressed_o),
        .out_err_o       (out_err_o)
    );

    // Memory responder: grant at negedge, respond in order one cycle after the handshake
    always @(negedge clk) begin
        if (!rstn) begin
            bus.instr_gnt_i    = 1'b0;
            bus.instr_rvalid_i = 1'b0;
            bus.instr_rdata_i  = '0;
            bus.instr_err_i    = 1'b0;
            q.delete();
        end else begin
            if (resp_en && q.size() > 0) begin
                resp_addr          = q.pop_front();
                bus.instr_rvalid_i = 1'b1;
                bus.instr_rdata_i  = mem.exists(resp_addr) ? mem[resp_addr] : 32'h0000_0013;
                bus.instr_err_i    = mem_err.exists(resp_addr) ? mem_err[resp_addr] : 1'b0;
                if (resp_addr >= 32'h500 && resp_addr < 32'h600)
                    stall_push++;
            end else begin
                bus.instr_rvalid_i = 1'b0;
                bus.instr_rdata_i  = '0;
                bus.instr_err_i    = 1'b0;
            end
            bus.instr_gnt_i = gnt_en;
            if (gnt_en && bus.instr_req_o)
                q.push_back(bus.instr_addr_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                                input logic comp, input logic err);
        int n = 0;
        while (!out_valid_o && n < 50) begin
            step();
            n++;
        end
        check({tag, " valid"}, {31'b0, out_valid_o}, 32'd1);
        check({tag, " pc"}, out_pc_o, pc);
        check({tag, " instr"}, out_instr_o, instr);
        check({tag, " compressed"}, {31'b0, out_compressed_o}, {31'b0, comp});
        check({tag, " err"}, {31'b0, out_err_o}, {31'b0, err});
        step();
    endtask

    task automatic redirect(input logic wb, input logic [31:0] wb_pc,
                            input logic alu, input logic [31:0] alu_pc);
        wb_change_pc_i  = wb;
        wb_next_pc_i    = wb_pc;
        alu_change_pc_i = alu;
        alu_next_pc_i   = alu_pc;
        #1;
        check("valid masked during redirect", {31'b0, out_valid_o}, 32'd0);
        step();
        wb_change_pc_i  = 1'b0;
        alu_change_pc_i = 1'b0;
    endtask

    // Directed sequence
    initial begin
        int n;
        int max_occ;

        mem[32'h80]  = 32'h0000_0013;
        mem[32'h84]  = 32'h0010_0093;
        mem[32'h0]   = 32'h4505_0505;
        mem[32'h100] = 32'h0093_0001;
        mem[32'h104] = 32'h0000_0010;
        mem[32'h300] = 32'h0050_0293;
        mem[32'h400] = 32'h0070_0393;
        mem[32'h500] = 32'h0010_0113;
        mem[32'h504] = 32'h0020_0193;
        mem[32'h508] = 32'h0030_0213;
        mem[32'h50c] = 32'h0040_0293;
        mem[32'h600] = 32'h0093_0001;
        mem[32'h604] = 32'h0000_0010;
        mem_err[32'h604] = 1'b1;

        // Reset state
        step();
        step();
        check("reset req", {31'b0, bus.instr_req_o}, 32'd0);
        check("reset addr", bus.instr_addr_o, 32'h80);
        check("reset pc", out_pc_o, 32'h80);
        check("reset valid", {31'b0, out_valid_o}, 32'd0);

        // 1: first request one cycle after reset release, two 32-bit instructions
        @(negedge clk);
        rstn = 1'b1;
        step();
        check("cycle1 req", {31'b0, bus.instr_req_o}, 32'd1);
        check("cycle1 addr", bus.instr_addr_o, 32'h80);
        expect_instr("t1 i0", 32'h80, 32'h0000_0013, 1'b0, 1'b0);
        expect_instr("t1 i1", 32'h84, 32'h0010_0093, 1'b0, 1'b0);

        // 2: two compressed instructions in one word
        redirect(1'b0, 32'h0, 1'b1, 32'h0);
        expect_instr("t2 c0", 32'h0, 32'h0000_0505, 1'b1, 1'b0);
        expect_instr("t2 c1", 32'h2, 32'h0000_4505, 1'b1, 1'b0);
        expect_instr("t2 next", 32'h4, 32'h0000_0013, 1'b0, 1'b0);

        // 3: halfword redirect, 32-bit instruction spanning two words
        redirect(1'b0, 32'h0, 1'b1, 32'h102);
        expect_instr("t3 span", 32'h102, 32'h0010_0093, 1'b0, 1'b0);

        // 4: two responses in flight, wb redirect wins over alu, stale words dropped
        resp_en = 1'b0;
        n = 0;
        while (q.size() != 2 && n < 50) begin
            step();
            n++;
        end
        check("t4 two in flight", q.size(), 32'd2);
        redirect(1'b1, 32'h300, 1'b1, 32'h400);
        resp_en = 1'b1;
        expect_instr("t4 wb target", 32'h300, 32'h0050_0293, 1'b0, 1'b0);
        expect_instr("t4 wb next", 32'h304, 32'h0000_0013, 1'b0, 1'b0);

        // 5: decode stalled 20 cycles with bus always granting and answering
        out_ready_i = 1'b0;
        redirect(1'b0, 32'h0, 1'b1, 32'h500);
        max_occ = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (stall_push + q.size() > max_occ)
                max_occ = stall_push + q.size();
        end
        check("t5 occupancy bounded", {31'b0, max_occ <= 3}, 32'd1);
        check("t5 words buffered", stall_push, 32'd3);
        check("t5 req dropped", {31'b0, bus.instr_req_o}, 32'd0);
        check("t5 held valid", {31'b0, out_valid_o}, 32'd1);
        check("t5 held pc", out_pc_o, 32'h500);
        check("t5 held instr", out_instr_o, 32'h0010_0113);
        out_ready_i = 1'b1;
        expect_instr("t5 w0", 32'h500, 32'h0010_0113, 1'b0, 1'b0);
        expect_instr("t5 w1", 32'h504, 32'h0020_0193, 1'b0, 1'b0);
        expect_instr("t5 w2", 32'h508, 32'h0030_0213, 1'b0, 1'b0);
        expect_instr("t5 w3", 32'h50c, 32'h0040_0293, 1'b0, 1'b0);

        // 6: error on the upper word of an unaligned 32-bit instruction
        redirect(1'b0, 32'h0, 1'b1, 32'h600);
        expect_instr("t6 good c", 32'h600, 32'h0000_0001, 1'b1, 1'b0);
        expect_instr("t6 err span", 32'h602, 32'h0010_0093, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
